// File: rtl/serial_loopback_pkg.sv
// serial_loopback_pkg: shared encodings for the buffered serial loopback.
// Mode codes, handshake FSM states and the default line terminator.
package serial_loopback_pkg;

    // Mode input encodings; code 3 is handled like MODE_PASS.
    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_LINE    = 2'd1;
    localparam logic [1:0] MODE_DISCARD = 2'd2;

    // Carriage return terminates a line in line mode.
    localparam logic [7:0] DEFAULT_EOL = 8'h0D;

    typedef enum logic {
        RX_IDLE,
        RX_ACK
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_REQ,
        TX_WAIT
    } tx_state_e;

endpackage

// File: rtl/serial_fifo_rel.sv
// serial_fifo_rel: synchronous FIFO with an extra release pointer.
// Only words between the read and release pointers may be transmitted.
module serial_fifo_rel #(
    parameter int P_DATA_W = 8,
    parameter int P_DEPTH  = 16,
    localparam int AW = $clog2(P_DEPTH),
    localparam int LW = $clog2(P_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [P_DATA_W-1:0] push_data,
    input  logic                pop,
    input  logic                rel_all,
    output logic [P_DATA_W-1:0] head,
    output logic [LW-1:0]       level,
    output logic                rel_avail,
    output logic                full,
    output logic                empty
);

    // Pointers carry one extra bit so a full buffer is distinguishable
    // from an empty one when computing the releasable span.
    logic [P_DATA_W-1:0] mem [P_DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [AW:0]         rel_ptr;
    logic [AW:0]         wr_nxt;
    logic [LW-1:0]       level_q;
    logic [LW-1:0]       level_nxt;
    logic                do_push;
    logic                do_pop;

    assign full      = (level_q == LW'(P_DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign rel_avail = (rel_ptr != rd_ptr);

    // Next write pointer and level, shared by the release logic.
    always_comb begin
        wr_nxt    = wr_ptr;
        level_nxt = level_q;
        if (do_push) begin
            wr_nxt = wr_ptr + (AW + 1)'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   level_nxt = level_q + LW'(1);
            2'b01:   level_nxt = level_q - LW'(1);
            default: level_nxt = level_q;
        endcase
    end

    // Pointer and level registers; becoming full forces a release so a
    // line that never terminates cannot deadlock the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rel_ptr <= '0;
            level_q <= '0;
        end else begin
            wr_ptr  <= wr_nxt;
            level_q <= level_nxt;
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
            if (rel_all || level_nxt == LW'(P_DEPTH)) begin
                rel_ptr <= wr_nxt;
            end
        end
    end

    // Word storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/serial_loopback_buf.sv
// serial_loopback_buf: buffered loopback between the deserializer and
// serializer four-phase handshakes, with line/discard modes and stats.
module serial_loopback_buf
    import serial_loopback_pkg::*;
#(
    parameter int                  P_DATA_W = 8,
    parameter int                  P_DEPTH  = 16,
    parameter logic [P_DATA_W-1:0] P_EOL    = P_DATA_W'(DEFAULT_EOL),
    parameter int                  P_CNT_W  = 16,
    localparam int                 LW       = $clog2(P_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [P_DATA_W-1:0] rx_data,
    input  logic                rx_req,
    output logic                rx_ack,
    output logic [P_DATA_W-1:0] tx_data,
    output logic                tx_req,
    input  logic                tx_ack,
    input  logic                clr_stat,
    output logic [LW-1:0]       fifo_level,
    output logic                overflow,
    output logic [P_CNT_W-1:0]  drop_count
);

    rx_state_e           rx_q;
    rx_state_e           rx_d;
    tx_state_e           tx_q;
    tx_state_e           tx_d;
    logic                rx_ack_d;
    logic                tx_req_d;
    logic [P_DATA_W-1:0] tx_data_d;
    logic [P_DATA_W-1:0] head;
    logic                rel_avail;
    logic                full;
    logic                empty;
    logic                rx_take;
    logic                keep;
    logic                push;
    logic                drop;
    logic                pop;
    logic                rel_all;

    // A word is taken once per transaction, on the first sampled request.
    // Full is judged on the current level, so a same-cycle pop never
    // makes room for the incoming word.
    assign rx_take = (rx_q == RX_IDLE) && rx_req;
    assign keep    = (mode != MODE_DISCARD);
    assign push    = rx_take && keep && !full;
    assign drop    = rx_take && keep && full;
    assign pop     = (tx_q == TX_REQ) && tx_ack && !empty;

    // Outside line mode everything stored is releasable, which also
    // flushes a pending line one cycle after leaving line mode.
    assign rel_all = (mode != MODE_LINE) || (push && rx_data == P_EOL);

    serial_fifo_rel #(
        .P_DATA_W (P_DATA_W),
        .P_DEPTH  (P_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (rx_data),
        .pop       (pop),
        .rel_all   (rel_all),
        .head      (head),
        .level     (fifo_level),
        .rel_avail (rel_avail),
        .full      (full),
        .empty     (empty)
    );

    // Receive side: acknowledge every request, then wait for it to drop.
    always_comb begin
        rx_d     = rx_q;
        rx_ack_d = rx_ack;
        unique case (rx_q)
            RX_IDLE: begin
                if (rx_req) begin
                    rx_d     = RX_ACK;
                    rx_ack_d = 1'b1;
                end
            end
            RX_ACK: begin
                if (!rx_req) begin
                    rx_d     = RX_IDLE;
                    rx_ack_d = 1'b0;
                end
            end
            default: begin
                rx_d     = RX_IDLE;
                rx_ack_d = 1'b0;
            end
        endcase
    end

    // Transmit side: present the head word, pop on acknowledge.
    always_comb begin
        tx_d      = tx_q;
        tx_req_d  = tx_req;
        tx_data_d = tx_data;
        unique case (tx_q)
            TX_IDLE: begin
                if (rel_avail) begin
                    tx_d      = TX_REQ;
                    tx_req_d  = 1'b1;
                    tx_data_d = head;
                end
            end
            TX_REQ: begin
                if (tx_ack) begin
                    tx_d     = TX_WAIT;
                    tx_req_d = 1'b0;
                end
            end
            TX_WAIT: begin
                if (!tx_ack) begin
                    tx_d = TX_IDLE;
                end
            end
            default: begin
                tx_d     = TX_IDLE;
                tx_req_d = 1'b0;
            end
        endcase
    end

    // State and registered handshake outputs for both sides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q    <= RX_IDLE;
            tx_q    <= TX_IDLE;
            rx_ack  <= 1'b0;
            tx_req  <= 1'b0;
            tx_data <= '0;
        end else begin
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            rx_ack  <= rx_ack_d;
            tx_req  <= tx_req_d;
            tx_data <= tx_data_d;
        end
    end

    // Drop statistics; a drop in the clear cycle counts as the first one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_stat) begin
                drop_count <= P_CNT_W'(1);
            end else if (!(&drop_count)) begin
                drop_count <= drop_count + P_CNT_W'(1);
            end
        end else if (clr_stat) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_serial_loopback_buf.sv
// tb_serial_loopback_buf: directed and randomized loopback checks
// against a queue-based model of the buffered loopback.
module tb_serial_loopback_buf;
    import serial_loopback_pkg::*;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int CW = 16;
    localparam int LW = $clog2(D + 1);
    localparam logic [7:0] EOL = 8'h0D;

    logic          clk;
    logic          rst_n;
    logic [1:0]    mode;
    logic [W-1:0]  rx_data;
    logic          rx_req;
    logic          rx_ack;
    logic [W-1:0]  tx_data;
    logic          tx_req;
    logic          tx_ack;
    logic          clr_stat;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [CW-1:0] drop_count;

    serial_loopback_buf #(
        .P_DATA_W (W),
        .P_DEPTH  (D),
        .P_EOL    (EOL),
        .P_CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .rx_data    (rx_data),
        .rx_req     (rx_req),
        .rx_ack     (rx_ack),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_ack     (tx_ack),
        .clr_stat   (clr_stat),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Model: accepted words in order, words seen on tx, release mark.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         rel_n    = 0;
    logic       m_ovf    = 1'b0;
    int         m_drop   = 0;
    logic [1:0] cur_mode = MODE_PASS;

    // Serializer stand-in: acks after ack_dly cycles unless stalled.
    int ack_dly  = 0;
    bit stall    = 1'b0;
    int wcnt     = 0;
    bit req_seen = 1'b0;

    initial begin
        tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_ack = 1'b0;
                wcnt   = 0;
            end else begin
                if (tx_req) req_seen = 1'b1;
                if (tx_req && !tx_ack && !stall) begin
                    if (wcnt >= ack_dly) begin
                        got_q.push_back(tx_data);
                        tx_ack = 1'b1;
                        wcnt   = 0;
                    end else begin
                        wcnt++;
                    end
                end else if (!tx_req && tx_ack) begin
                    tx_ack = 1'b0;
                end
            end
        end
    end

    task automatic m_rx(input logic [7:0] w, input bit clr);
        bit dropped = 1'b0;
        if (cur_mode != MODE_DISCARD) begin
            if (exp_q.size() - got_q.size() >= D) begin
                dropped = 1'b1;
            end else begin
                exp_q.push_back(w);
                if (cur_mode != MODE_LINE || w == EOL ||
                    exp_q.size() - got_q.size() == D)
                    rel_n = exp_q.size();
            end
        end
        if (dropped) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : (m_drop == 65535 ? m_drop : m_drop + 1);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
    endtask

    task automatic send(input logic [7:0] w, input bit clr);
        int n;
        @(negedge clk);
        rx_data  = w;
        rx_req   = 1'b1;
        clr_stat = clr;
        @(negedge clk);
        clr_stat = 1'b0;
        chk("rx_ack_rise", 32'(rx_ack), 32'd1);
        m_rx(w, clr);
        rx_req = 1'b0;
        n = 0;
        while (rx_ack && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("rx_ack_fall", 32'(rx_ack), 32'd0);
        rx_data = 8'($urandom);
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        if (cur_mode == MODE_LINE && m != MODE_LINE)
            rel_n = exp_q.size();
        cur_mode = m;
        mode     = m;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        int k;
        while ((got_q.size() < rel_n || tx_req || tx_ack) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_txcnt"}, 32'(got_q.size()), 32'(rel_n));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_txdata"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_level"}, 32'(fifo_level),
            32'(exp_q.size() - got_q.size()));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_drops"}, 32'(drop_count), 32'(m_drop));
        k = got_q.size();
        for (int i = 0; i < k; i++) begin
            void'(got_q.pop_front());
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        rel_n = (rel_n > k) ? rel_n - k : 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        int lat;
        logic [1:0] m;
        logic [7:0] w;

        rst_n    = 1'b0;
        mode     = MODE_PASS;
        rx_data  = '0;
        rx_req   = 1'b0;
        clr_stat = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_ack", 32'(rx_ack), 32'd0);
        chk("rst_tx_req", 32'(tx_req), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        rst_n = 1'b1;

        // Passthrough latency: ack at N+1, tx_req with data at N+2.
        ack_dly = 2;
        @(negedge clk);
        rx_data = 8'h41;
        rx_req  = 1'b1;
        @(negedge clk);
        chk("lat_rx_ack", 32'(rx_ack), 32'd1);
        chk("lat_tx_early", 32'(tx_req), 32'd0);
        m_rx(8'h41, 1'b0);
        rx_req = 1'b0;
        @(negedge clk);
        chk("lat_tx_req", 32'(tx_req), 32'd1);
        chk("lat_tx_data", 32'(tx_data), 32'h41);
        drain("pass");

        // Line mode holds "ABC" until the terminator arrives.
        ack_dly = 1;
        set_mode(MODE_LINE);
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        drain("line_hold");
        send(EOL, 1'b0);
        drain("line_eol");

        // Stalled serializer: 20 words into 16 slots, then clear stats.
        set_mode(MODE_PASS);
        ack_dly = 0;
        stall   = 1'b1;
        for (int i = 0; i < 20; i++) send(8'(8'h60 + i), 1'b0);
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drops", 32'(drop_count), 32'd4);
        send(8'hAA, 1'b1);
        chk("clr_drop_ovf", 32'(overflow), 32'd1);
        chk("clr_drop_cnt", 32'(drop_count), 32'd1);
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_drops", 32'(drop_count), 32'd0);
        stall = 1'b0;
        drain("ovf_drain");

        // Unterminated line is forced out when the buffer fills.
        set_mode(MODE_LINE);
        for (int i = 0; i < 15; i++) send(8'(8'h20 + i), 1'b0);
        drain("force_hold");
        send(8'h2F, 1'b0);
        drain("force_rel");

        // Leaving line mode releases the pending words one cycle later.
        send(8'h51, 1'b0);
        send(8'h52, 1'b0);
        send(8'h53, 1'b0);
        drain("sw_hold");
        set_mode(MODE_PASS);
        repeat (2) @(negedge clk);
        chk("sw_tx_req", 32'(tx_req), 32'd1);
        drain("sw_rel");

        // Discard mode acknowledges but never stores or counts.
        set_mode(MODE_DISCARD);
        req_seen = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(8'h70 + i), 1'b0);
        repeat (4) @(negedge clk);
        chk("disc_no_tx", 32'(req_seen), 32'd0);
        drain("disc");

        // Asynchronous reset during an outstanding transmit request.
        set_mode(MODE_PASS);
        stall = 1'b1;
        send(8'h77, 1'b0);
        lat = 0;
        while (!tx_req && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("rst_pre_tx_req", 32'(tx_req), 32'd1);
        @(negedge clk);
        rx_data = 8'h88;
        rx_req  = 1'b1;
        @(negedge clk);
        chk("rst_pre_rx_ack", 32'(rx_ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_req", 32'(tx_req), 32'd0);
        chk("arst_rx_ack", 32'(rx_ack), 32'd0);
        chk("arst_level", 32'(fifo_level), 32'd0);
        rx_req = 1'b0;
        exp_q.delete();
        got_q.delete();
        rel_n  = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        send(8'h99, 1'b0);
        drain("post_rst");

        // Randomized bursts across all modes with varying ack delay.
        for (int r = 0; r < 12; r++) begin
            m = 2'($urandom_range(0, 3));
            set_mode(m);
            ack_dly = $urandom_range(0, 3);
            nw = $urandom_range(1, 10);
            for (int i = 0; i < nw; i++) begin
                w = ($urandom_range(0, 3) == 0) ? EOL : 8'($urandom);
                send(w, $urandom_range(0, 7) == 0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            drain("rnd");
            if (m == MODE_LINE) begin
                set_mode(MODE_PASS);
                drain("rnd_flush");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
